wired_branch_predictor: RTL

//  Front-end predictor: for each fetch PC it predicts branch direction, target and type (call/return/direct).

---
 rtl/wired_branch_predictor.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/wired_branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB with 2-bit counters and a
// speculative circular return-address stack repaired from resolution checkpoints.
module wired_branch_predictor #(
  parameter int unsigned BTB_ENTRIES = 64,
  parameter int unsigned TAG_W       = 12,
  parameter int unsigned RAS_DEPTH   = 8,
  localparam int unsigned IDX_W      = $clog2(BTB_ENTRIES),
  localparam int unsigned PTR_W      = $clog2(RAS_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  input  logic [31:0]      req_pc_i,
  output logic             pred_valid_o,
  output logic             pred_taken_o,
  output logic [31:0]      pred_target_o,
  output logic [1:0]       pred_type_o,
  output logic [PTR_W-1:0] pred_ras_ptr_o,
  input  logic             upd_valid_i,
  input  logic [31:0]      upd_pc_i,
  input  logic             upd_taken_i,
  input  logic [31:0]      upd_target_i,
  input  logic [1:0]       upd_type_i,
  input  logic             upd_mispred_i,
  input  logic [PTR_W-1:0] upd_ras_ptr_i
);

  localparam logic [1:0] TY_NONE = 2'd0;
  localparam logic [1:0] TY_CALL = 2'd1;
  localparam logic [1:0] TY_RET  = 2'd2;
  localparam logic [1:0] TY_DIR  = 2'd3;

  logic [BTB_ENTRIES-1:0] btb_valid_q, btb_valid_d;
  logic [TAG_W-1:0]       btb_tag_q  [BTB_ENTRIES];
  logic [31:0]            btb_tgt_q  [BTB_ENTRIES];
  logic [1:0]             btb_type_q [BTB_ENTRIES];
  logic [1:0]             btb_cnt_q  [BTB_ENTRIES];
  logic [31:0]            ras_q      [RAS_DEPTH];
  logic [PTR_W-1:0]       ptr_q, ptr_d;

  logic        lk_valid_q, lk_valid_d;
  logic        lk_hit_q, lk_hit_d;
  logic [31:0] lk_pc_q, lk_pc_d;
  logic [31:0] lk_tgt_q, lk_tgt_d;
  logic [1:0]  lk_type_q, lk_type_d;
  logic [1:0]  lk_cnt_q, lk_cnt_d;

  logic [IDX_W-1:0] req_idx, upd_idx;
  logic [TAG_W-1:0] req_tag, upd_tag;
  logic             upd_hit, btb_we;
  logic [1:0]       cnt_new;
  logic             ras_we;
  logic [PTR_W-1:0] ras_waddr;
  logic [31:0]      ras_wdata, lk_pc4;

  // Lookup stage: arrays are sampled at the request edge, so a same-cycle
  // update is not visible to the lookup (read-before-write).
  always_comb begin
    req_idx    = req_pc_i[2 +: IDX_W];
    req_tag    = req_pc_i[2+IDX_W +: TAG_W];
    lk_valid_d = req_valid_i;
    lk_hit_d   = req_valid_i && btb_valid_q[req_idx] && (btb_tag_q[req_idx] == req_tag);
    lk_pc_d    = req_pc_i;
    lk_tgt_d   = btb_tgt_q[req_idx];
    lk_type_d  = btb_type_q[req_idx];
    lk_cnt_d   = btb_cnt_q[req_idx];
  end

  always_comb begin
    upd_idx = upd_pc_i[2 +: IDX_W];
    upd_tag = upd_pc_i[2+IDX_W +: TAG_W];
    upd_hit = btb_valid_q[upd_idx] && (btb_tag_q[upd_idx] == upd_tag);
    btb_we  = upd_valid_i && (upd_type_i != TY_NONE);
    if (upd_hit) begin
      if (upd_taken_i) cnt_new = (btb_cnt_q[upd_idx] == 2'b11) ? 2'b11 : btb_cnt_q[upd_idx] + 2'd1;
      else             cnt_new = (btb_cnt_q[upd_idx] == 2'b00) ? 2'b00 : btb_cnt_q[upd_idx] - 2'd1;
    end else begin
      cnt_new = upd_taken_i ? 2'b10 : 2'b01;
    end
    btb_valid_d = btb_valid_q;
    if (btb_we)                      btb_valid_d[upd_idx] = 1'b1;
    else if (upd_valid_i && upd_hit) btb_valid_d[upd_idx] = 1'b0;
  end

  always_comb begin
    lk_pc4         = lk_pc_q + 32'd4;
    pred_valid_o   = lk_valid_q;
    pred_taken_o   = 1'b0;
    pred_target_o  = lk_valid_q ? lk_pc4 : '0;
    pred_type_o    = TY_NONE;
    pred_ras_ptr_o = lk_valid_q ? ptr_q : '0;
    if (lk_valid_q && lk_hit_q) begin
      case (lk_type_q)
        TY_CALL: begin
          pred_taken_o  = 1'b1;
          pred_target_o = lk_tgt_q;
          pred_type_o   = TY_CALL;
        end
        TY_RET: begin
          pred_taken_o  = 1'b1;
          pred_target_o = ras_q[ptr_q - PTR_W'(1)];
          pred_type_o   = TY_RET;
        end
        TY_DIR: begin
          pred_taken_o  = lk_cnt_q[1];
          pred_target_o = lk_cnt_q[1] ? lk_tgt_q : lk_pc4;
          pred_type_o   = TY_DIR;
        end
        default: ;
      endcase
    end
  end

  // A mispredict repair overrides any speculative push/pop from the prediction stage.
  always_comb begin
    ptr_d     = ptr_q;
    ras_we    = 1'b0;
    ras_waddr = ptr_q;
    ras_wdata = lk_pc4;
    if (lk_valid_q && lk_hit_q && lk_type_q == TY_CALL) begin
      ras_we = 1'b1;
      ptr_d  = ptr_q + PTR_W'(1);
    end else if (lk_valid_q && lk_hit_q && lk_type_q == TY_RET) begin
      ptr_d = ptr_q - PTR_W'(1);
    end
    if (upd_valid_i && upd_mispred_i) begin
      ras_we = 1'b0;
      case (upd_type_i)
        TY_CALL: begin
          ras_we    = 1'b1;
          ras_waddr = upd_ras_ptr_i;
          ras_wdata = upd_pc_i + 32'd4;
          ptr_d     = upd_ras_ptr_i + PTR_W'(1);
        end
        TY_RET:  ptr_d = upd_ras_ptr_i - PTR_W'(1);
        default: ptr_d = upd_ras_ptr_i;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btb_valid_q <= '0;
      ptr_q       <= '0;
      lk_valid_q  <= 1'b0;
      lk_hit_q    <= 1'b0;
      lk_pc_q     <= '0;
      lk_tgt_q    <= '0;
      lk_type_q   <= '0;
      lk_cnt_q    <= '0;
    end else begin
      btb_valid_q <= btb_valid_d;
      ptr_q       <= ptr_d;
      lk_valid_q  <= lk_valid_d;
      lk_hit_q    <= lk_hit_d;
      lk_pc_q     <= lk_pc_d;
      lk_tgt_q    <= lk_tgt_d;
      lk_type_q   <= lk_type_d;
      lk_cnt_q    <= lk_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (btb_we) begin
      btb_tag_q[upd_idx]  <= upd_tag;
      btb_tgt_q[upd_idx]  <= upd_target_i;
      btb_type_q[upd_idx] <= upd_type_i;
      btb_cnt_q[upd_idx]  <= cnt_new;
    end
    if (ras_we) ras_q[ras_waddr] <= ras_wdata;
  end

endmodule
